// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, register ids and datapath width.
package y86_pkg;

    localparam int DATA_W = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

endpackage

// File: rtl/y86_regbank.sv
// 15-entry register bank with two write ports (M beats E) and two bypassed read ports.
// Latency: writes commit at the edge; reads are combinational and see same-cycle writes.
// Backpressure: none; writes are accepted every cycle wb_en is high.
module y86_regbank #(
    parameter int              DATA_W     = y86_pkg::DATA_W,
    parameter logic [DATA_W-1:0] STACK_INIT = DATA_W'(64'h200)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [3:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic [3:0]        srca,
    input  logic [3:0]        srcb,
    output logic [DATA_W-1:0] rda,
    output logic [DATA_W-1:0] rdb
);
    import y86_pkg::*;

    logic [DATA_W-1:0] regs [15];

    // M port is checked first so popq %rsp leaves the popped value in %rsp.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 15; i++) begin
            if (reset)
                regs[i] <= (4'(i) == R_RSP) ? STACK_INIT : '0;
            else if (wb_en && dstM == 4'(i))
                regs[i] <= valM;
            else if (wb_en && dstE == 4'(i))
                regs[i] <= valE;
        end
    end

    function automatic logic [DATA_W-1:0] rd(input logic [3:0] s);
        if (s == R_NONE)                 return '0;
        else if (wb_en && dstM == s)     return valM;
        else if (wb_en && dstE == s)     return valE;
        else                             return regs[s];
    endfunction

    always_comb begin
        rda = rd(srca);
        rdb = rd(srcb);
    end

endmodule

// File: rtl/y86_regfile_decode.sv
// Decode-side register file: derives srcA/srcB from icode and registers the operands.
// Latency: 1 cycle from dec_valid to out_valid, 1 request per cycle.
// Backpressure: stall freezes every decode output; register writes still commit.
module y86_regfile_decode #(
    parameter int                DATA_W     = y86_pkg::DATA_W,
    parameter logic [DATA_W-1:0] STACK_INIT = DATA_W'(64'h0000_0000_0000_0200)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic              stall,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              wb_en,
    input  logic [3:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valM,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [3:0]        srcA_q,
    output logic [3:0]        srcB_q,
    output logic              out_valid
);
    import y86_pkg::*;

    logic [3:0]        srca, srcb;
    logic [DATA_W-1:0] rda, rdb;

    always_comb begin
        srca = R_NONE;
        case (icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srca = rA;
            I_RET, I_POPQ:                      srca = R_RSP;
            default:                            srca = R_NONE;
        endcase
    end

    always_comb begin
        srcb = R_NONE;
        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          srcb = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     srcb = R_RSP;
            default:                            srcb = R_NONE;
        endcase
    end

    y86_regbank #(
        .DATA_W     (DATA_W),
        .STACK_INIT (STACK_INIT)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .wb_en (wb_en),
        .dstE  (dstE),
        .valE  (valE),
        .dstM  (dstM),
        .valM  (valM),
        .srca  (srca),
        .srcb  (srcb),
        .rda   (rda),
        .rdb   (rdb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            valA      <= '0;
            valB      <= '0;
            srcA_q    <= R_NONE;
            srcB_q    <= R_NONE;
        end else if (!stall) begin
            out_valid <= dec_valid;
            if (dec_valid) begin
                valA   <= rda;
                valB   <= rdb;
                srcA_q <= srca;
                srcB_q <= srcb;
            end
        end
    end

endmodule

// File: tb/tb_y86_regfile_decode.sv
// Directed bench for y86_regfile_decode: a per-cycle vector table plus a fill/readback sweep.
module tb_y86_regfile_decode;

    logic        clk = 1'b0;
    logic        reset, dec_valid, stall, wb_en;
    logic [3:0]  icode, rA, rB, dstE, dstM;
    logic [63:0] valE, valM;
    logic [63:0] valA, valB;
    logic [3:0]  srcA_q, srcB_q;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    y86_regfile_decode dut (
        .clk       (clk),
        .reset     (reset),
        .dec_valid (dec_valid),
        .stall     (stall),
        .icode     (icode),
        .rA        (rA),
        .rB        (rB),
        .wb_en     (wb_en),
        .dstE      (dstE),
        .valE      (valE),
        .dstM      (dstM),
        .valM      (valM),
        .valA      (valA),
        .valB      (valB),
        .srcA_q    (srcA_q),
        .srcB_q    (srcB_q),
        .out_valid (out_valid)
    );

    typedef struct {
        logic        rst, dv, st;
        logic [3:0]  ic, ra, rb;
        logic        we;
        logic [3:0]  de;
        logic [63:0] ve;
        logic [3:0]  dm;
        logic [63:0] vm;
        logic        ov;
        logic [3:0]  sa, sb;
        logic [63:0] va, vb;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rst, logic dv, logic st, logic [3:0] ic, logic [3:0] ra,
                                logic [3:0] rb, logic we, logic [3:0] de, logic [63:0] ve,
                                logic [3:0] dm, logic [63:0] vm, logic ov, logic [3:0] sa,
                                logic [3:0] sb, logic [63:0] va, logic [63:0] vb);
        vec_t v;
        v.rst = rst; v.dv = dv; v.st = st; v.ic = ic; v.ra = ra; v.rb = rb;
        v.we = we; v.de = de; v.ve = ve; v.dm = dm; v.vm = vm;
        v.ov = ov; v.sa = sa; v.sb = sb; v.va = va; v.vb = vb;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; dec_valid = v.dv; stall = v.st;
        icode = v.ic; rA = v.ra; rB = v.rb;
        wb_en = v.we; dstE = v.de; valE = v.ve; dstM = v.dm; valM = v.vm;
    endtask

    task automatic check_outs(input int idx, input logic ov, input logic [3:0] sa,
                              input logic [3:0] sb, input logic [63:0] va, input logic [63:0] vb);
        chk("out_valid", idx, 64'(out_valid), 64'(ov));
        chk("srcA_q", idx, 64'(srcA_q), 64'(sa));
        chk("srcB_q", idx, 64'(srcB_q), 64'(sb));
        chk("valA", idx, valA, va);
        chk("valB", idx, valB, vb);
    endtask

    initial begin
        vec_t v;
        //                 rst dv st ic    ra    rb    we de    ve           dm    vm           ov sa    sb    va           vb
        vq.push_back(mk(1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 4'hF, 64'h0,      4'hF, 64'h0,      0, 4'hF, 4'hF, 64'h0,      64'h0));
        vq.push_back(mk(0, 1, 0, 4'h9, 4'h0, 4'h0, 0, 4'hF, 64'h0,      4'hF, 64'h0,      1, 4'h4, 4'h4, 64'h200,    64'h200));
        vq.push_back(mk(0, 1, 0, 4'h2, 4'h3, 4'h0, 1, 4'h3, 64'h1234,   4'hF, 64'h0,      1, 4'h3, 4'hF, 64'h1234,   64'h0));
        vq.push_back(mk(0, 1, 0, 4'h6, 4'h3, 4'h3, 0, 4'hF, 64'h0,      4'hF, 64'h0,      1, 4'h3, 4'h3, 64'h1234,   64'h1234));
        vq.push_back(mk(0, 1, 0, 4'hA, 4'h0, 4'h0, 1, 4'h4, 64'h1F8,    4'h4, 64'hABCD,   1, 4'h0, 4'h4, 64'h0,      64'hABCD));
        vq.push_back(mk(0, 1, 0, 4'hB, 4'h0, 4'h0, 0, 4'hF, 64'h0,      4'hF, 64'h0,      1, 4'h4, 4'h4, 64'hABCD,   64'hABCD));
        vq.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 1, 4'h5, 64'h55,     4'hF, 64'h0,      0, 4'h4, 4'h4, 64'hABCD,   64'hABCD));
        vq.push_back(mk(0, 1, 1, 4'h6, 4'h5, 4'h5, 0, 4'hF, 64'h0,      4'hF, 64'h0,      0, 4'h4, 4'h4, 64'hABCD,   64'hABCD));
        vq.push_back(mk(0, 1, 1, 4'h6, 4'h5, 4'h5, 1, 4'h6, 64'h66,     4'hF, 64'h0,      0, 4'h4, 4'h4, 64'hABCD,   64'hABCD));
        vq.push_back(mk(0, 1, 1, 4'h6, 4'h5, 4'h5, 0, 4'hF, 64'h0,      4'hF, 64'h0,      0, 4'h4, 4'h4, 64'hABCD,   64'hABCD));
        vq.push_back(mk(0, 1, 0, 4'h6, 4'h5, 4'h5, 0, 4'hF, 64'h0,      4'hF, 64'h0,      1, 4'h5, 4'h5, 64'h55,     64'h55));
        vq.push_back(mk(0, 1, 0, 4'h4, 4'h6, 4'h5, 0, 4'hF, 64'h0,      4'hF, 64'h0,      1, 4'h6, 4'h5, 64'h66,     64'h55));
        vq.push_back(mk(0, 1, 0, 4'hC, 4'h1, 4'h2, 1, 4'hF, 64'hFFFF,   4'hF, 64'h0,      1, 4'hF, 4'hF, 64'h0,      64'h0));
        vq.push_back(mk(0, 1, 0, 4'h6, 4'h0, 4'h7, 0, 4'hF, 64'h0,      4'hF, 64'h0,      1, 4'h0, 4'h7, 64'h0,      64'h0));
        vq.push_back(mk(0, 1, 0, 4'h6, 4'h7, 4'h8, 1, 4'h7, 64'h7777,   4'h8, 64'h8888,   1, 4'h7, 4'h8, 64'h7777,   64'h8888));
        vq.push_back(mk(0, 1, 0, 4'h6, 4'h8, 4'h7, 0, 4'hF, 64'h0,      4'hF, 64'h0,      1, 4'h8, 4'h7, 64'h8888,   64'h7777));
        vq.push_back(mk(0, 1, 0, 4'h9, 4'h0, 4'h0, 0, 4'h4, 64'h999,    4'h4, 64'h999,    1, 4'h4, 4'h4, 64'hABCD,   64'hABCD));
        vq.push_back(mk(0, 1, 0, 4'hB, 4'h0, 4'h0, 0, 4'hF, 64'h0,      4'hF, 64'h0,      1, 4'h4, 4'h4, 64'hABCD,   64'hABCD));
        vq.push_back(mk(1, 1, 0, 4'h2, 4'h0, 4'h0, 1, 4'h0, 64'h77,     4'hF, 64'h0,      0, 4'hF, 4'hF, 64'h0,      64'h0));
        vq.push_back(mk(0, 1, 0, 4'h9, 4'h0, 4'h0, 0, 4'hF, 64'h0,      4'hF, 64'h0,      1, 4'h4, 4'h4, 64'h200,    64'h200));
        vq.push_back(mk(0, 1, 0, 4'h2, 4'h0, 4'h0, 0, 4'hF, 64'h0,      4'hF, 64'h0,      1, 4'h0, 4'hF, 64'h0,      64'h0));
        vq.push_back(mk(0, 1, 0, 4'h5, 4'h3, 4'h4, 0, 4'hF, 64'h0,      4'hF, 64'h0,      1, 4'hF, 4'h4, 64'h0,      64'h200));
        vq.push_back(mk(0, 1, 0, 4'h8, 4'h4, 4'h3, 0, 4'hF, 64'h0,      4'hF, 64'h0,      1, 4'hF, 4'h4, 64'h0,      64'h200));
        vq.push_back(mk(0, 1, 0, 4'h3, 4'h4, 4'h4, 0, 4'hF, 64'h0,      4'hF, 64'h0,      1, 4'hF, 4'hF, 64'h0,      64'h0));
        vq.push_back(mk(0, 1, 0, 4'h7, 4'h4, 4'h4, 0, 4'hF, 64'h0,      4'hF, 64'h0,      1, 4'hF, 4'hF, 64'h0,      64'h0));
        vq.push_back(mk(0, 1, 0, 4'h4, 4'h4, 4'h4, 0, 4'hF, 64'h0,      4'hF, 64'h0,      1, 4'h4, 4'h4, 64'h200,    64'h200));

        v = mk(1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 4'hF, 64'h0, 4'hF, 64'h0, 0, 4'hF, 4'hF, 64'h0, 64'h0);
        drive(v);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i]);
            @(posedge clk);
            #1;
            check_outs(i, vq[i].ov, vq[i].sa, vq[i].sb, vq[i].va, vq[i].vb);
        end

        // Fill every register through the M port, then read all of them back in pairs.
        for (int r = 0; r < 15; r++) begin
            @(negedge clk);
            v = mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 1, 4'hF, 64'h0, 4'(r), 64'hC0DE_0000 + 64'(r),
                   0, 4'h0, 4'h0, 64'h0, 64'h0);
            drive(v);
        end
        for (int r = 0; r < 15; r++) begin
            @(negedge clk);
            v = mk(0, 1, 0, 4'h6, 4'(r), 4'(14 - r), 0, 4'hF, 64'h0, 4'hF, 64'h0,
                   0, 4'h0, 4'h0, 64'h0, 64'h0);
            drive(v);
            @(posedge clk);
            #1;
            check_outs(100 + r, 1'b1, 4'(r), 4'(14 - r),
                       64'hC0DE_0000 + 64'(r), 64'hC0DE_0000 + 64'(14 - r));
        end

        // dec_valid low with no stall: out_valid drops, operands hold.
        @(negedge clk);
        v = mk(0, 0, 0, 4'h6, 4'h1, 4'h2, 0, 4'hF, 64'h0, 4'hF, 64'h0, 0, 4'h0, 4'h0, 64'h0, 64'h0);
        drive(v);
        @(posedge clk);
        #1;
        check_outs(200, 1'b0, 4'hE, 4'h0, 64'hC0DE_000E, 64'hC0DE_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
